// File: rtl/id_ex_stage.sv
// ID/EX boundary register for the RV32I pipeline: captures decoded operands,
// forwards EX/MEM and MEM/WB results, and detects load-use hazards.
module id_ex_stage #(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [size-1:0] id_pc,
  input  logic [size-1:0] id_imm,
  input  logic [size-1:0] id_rs1_data,
  input  logic [size-1:0] id_rs2_data,
  input  logic [4:0]      id_rs1_addr,
  input  logic [4:0]      id_rs2_addr,
  input  logic [4:0]      id_rd_addr,
  input  logic [3:0]      id_fu_sel,
  input  logic            id_use_pc,
  input  logic            id_use_imm,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic [4:0]      exm_rd_addr,
  input  logic            exm_reg_write,
  input  logic [size-1:0] exm_result,
  input  logic [4:0]      mwb_rd_addr,
  input  logic            mwb_reg_write,
  input  logic [size-1:0] mwb_result,
  output logic [size-1:0] fu_a,
  output logic [size-1:0] fu_b,
  output logic [3:0]      fu_sel,
  output logic [size-1:0] ex_store_data,
  output logic [size-1:0] ex_pc,
  output logic [4:0]      ex_rd_addr,
  output logic            ex_valid,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            load_use_stall
);

  logic            vld_p1;
  logic [size-1:0] pc_p1;
  logic [size-1:0] imm_p1;
  logic [size-1:0] rs1_data_p1;
  logic [size-1:0] rs2_data_p1;
  logic [4:0]      rs1_addr_p1;
  logic [4:0]      rs2_addr_p1;
  logic [4:0]      rd_p1;
  logic [3:0]      sel_p1;
  logic            use_pc_p1;
  logic            use_imm_p1;
  logic            reg_write_p1;
  logic            mem_read_p1;
  logic            mem_write_p1;

  logic            mwb_hit_rs1;
  logic            mwb_hit_rs2;
  logic [size-1:0] fwd_rs1;
  logic [size-1:0] fwd_rs2;

  // Forwarding select: youngest producer (EX/MEM) wins, x0 is never forwarded.
  function automatic logic [size-1:0] fwd_sel(
    input logic [4:0]      addr,
    input logic [size-1:0] stored,
    input logic [4:0]      e_rd,
    input logic            e_we,
    input logic [size-1:0] e_res,
    input logic [4:0]      m_rd,
    input logic            m_we,
    input logic [size-1:0] m_res
  );
    logic [size-1:0] r;
    r = stored;
    if (addr != 5'd0) begin
      if (e_we && (e_rd == addr))
        r = e_res;
      else if (m_we && (m_rd == addr))
        r = m_res;
    end
    return r;
  endfunction

  assign load_use_stall = vld_p1 & mem_read_p1 & (rd_p1 != 5'd0) & id_valid & ~flush &
                          ((rd_p1 == id_rs1_addr) | (rd_p1 == id_rs2_addr));

  // Value being written back this cycle supersedes the stale register-file read.
  assign mwb_hit_rs1 = mwb_reg_write & (mwb_rd_addr != 5'd0) & (mwb_rd_addr == id_rs1_addr);
  assign mwb_hit_rs2 = mwb_reg_write & (mwb_rd_addr != 5'd0) & (mwb_rd_addr == id_rs2_addr);

  // ---- ID -> EX register (p1) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1       <= 1'b0;
      pc_p1        <= '0;
      imm_p1       <= '0;
      rs1_data_p1  <= '0;
      rs2_data_p1  <= '0;
      rs1_addr_p1  <= '0;
      rs2_addr_p1  <= '0;
      rd_p1        <= '0;
      sel_p1       <= '0;
      use_pc_p1    <= 1'b0;
      use_imm_p1   <= 1'b0;
      reg_write_p1 <= 1'b0;
      mem_read_p1  <= 1'b0;
      mem_write_p1 <= 1'b0;
    end else if (hold) begin
      vld_p1 <= vld_p1;
    end else if (flush || load_use_stall || !id_valid) begin
      vld_p1       <= 1'b0;
      pc_p1        <= '0;
      imm_p1       <= '0;
      rs1_data_p1  <= '0;
      rs2_data_p1  <= '0;
      rs1_addr_p1  <= '0;
      rs2_addr_p1  <= '0;
      rd_p1        <= '0;
      sel_p1       <= '0;
      use_pc_p1    <= 1'b0;
      use_imm_p1   <= 1'b0;
      reg_write_p1 <= 1'b0;
      mem_read_p1  <= 1'b0;
      mem_write_p1 <= 1'b0;
    end else begin
      vld_p1       <= 1'b1;
      pc_p1        <= id_pc;
      imm_p1       <= id_imm;
      rs1_data_p1  <= mwb_hit_rs1 ? mwb_result : id_rs1_data;
      rs2_data_p1  <= mwb_hit_rs2 ? mwb_result : id_rs2_data;
      rs1_addr_p1  <= id_rs1_addr;
      rs2_addr_p1  <= id_rs2_addr;
      rd_p1        <= id_rd_addr;
      sel_p1       <= id_fu_sel;
      use_pc_p1    <= id_use_pc;
      use_imm_p1   <= id_use_imm;
      reg_write_p1 <= id_reg_write;
      mem_read_p1  <= id_mem_read;
      mem_write_p1 <= id_mem_write;
    end
  end

  // ---- EX operand forwarding and source select ----
  always_comb begin
    fwd_rs1 = fwd_sel(rs1_addr_p1, rs1_data_p1, exm_rd_addr, exm_reg_write, exm_result,
                      mwb_rd_addr, mwb_reg_write, mwb_result);
    fwd_rs2 = fwd_sel(rs2_addr_p1, rs2_data_p1, exm_rd_addr, exm_reg_write, exm_result,
                      mwb_rd_addr, mwb_reg_write, mwb_result);
  end

  assign fu_a          = use_pc_p1  ? pc_p1  : fwd_rs1;
  assign fu_b          = use_imm_p1 ? imm_p1 : fwd_rs2;
  assign fu_sel        = sel_p1;
  assign ex_store_data = fwd_rs2;
  assign ex_pc         = pc_p1;
  assign ex_rd_addr    = rd_p1;
  assign ex_valid      = vld_p1;
  assign ex_reg_write  = reg_write_p1;
  assign ex_mem_read   = mem_read_p1;
  assign ex_mem_write  = mem_write_p1;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode/execute boundary register with operand forwarding for the 5-stage RV32I pipeline. Captures decoded operands and control from ID each cycle and presents forwarded, source-selected `A`, `B` and the 4-bit `Sel` to the execute-stage functional unit (ALU/shifter). Detects load-use hazards and inserts a one-cycle bubble. Honours an external hold and a flush from branch resolution.

## Interface
- `size`, 32, datapath width of operands, immediates, PC and results
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `hold`  in  1  freeze EX register (memory stall)
- `flush`  in  1  kill instruction entering EX (taken branch/jump)
- `id_valid`  in  1  ID holds a real instruction
- `id_pc`, `id_imm`, `id_rs1_data`, `id_rs2_data`  in  size  decoded values; rs data comes from the register file read
- `id_rs1_addr`, `id_rs2_addr`, `id_rd_addr`  in  5  register indices
- `id_fu_sel`  in  4  FU select; bit 3 = shifter, bits 2:0 = ALU op
- `id_use_pc`, `id_use_imm`, `id_reg_write`, `id_mem_read`, `id_mem_write`  in  1  control
- `exm_rd_addr`  in  5  / `exm_reg_write`  in  1  / `exm_result`  in  size  EX/MEM writeback candidate
- `mwb_rd_addr`  in  5  / `mwb_reg_write`  in  1  / `mwb_result`  in  size  MEM/WB writeback value
- `fu_a`, `fu_b`  out  size  FU operands
- `fu_sel`  out  4  FU select
- `ex_store_data`  out  size  forwarded rs2 for stores
- `ex_pc`  out  size; `ex_rd_addr`  out  5; `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`  out  1
- `load_use_stall`  out  1  ID/IF must hold this cycle

## Operation
- EX register holds: valid, pc, imm, rs1/rs2 data and addresses, rd, fu_sel, use_pc, use_imm, reg_write, mem_read, mem_write.
- Update priority on each rising edge: reset > `hold` (keep all) > `flush` (load bubble) > `load_use_stall` (load bubble) > load from ID.
- Bubble: valid, reg_write, mem_read, mem_write = 0; rd = 0; fu_sel = 0; data fields don't care but set 0.
- Bubble loaded when `id_valid`=0, or any field loaded from ID with valid=0: reg_write/mem_read/mem_write forced 0.
- Capture bypass: on load from ID, if `mwb_reg_write` and `mwb_rd_addr`≠0 equals `id_rs1_addr` (resp. rs2), capture `mwb_result` instead of `id_rs1_data` (resp. rs2).
- Forwarding (combinational, from stored rs addresses), per operand: EX/MEM match (`exm_reg_write`, addr≠0, equal) → `exm_result`; else MEM/WB match → `mwb_result`; else stored data. EX/MEM wins over MEM/WB. x0 never forwarded.
- `fu_a` = `use_pc` ? pc : fwd_rs1. `fu_b` = `use_imm` ? imm : fwd_rs2. `ex_store_data` = fwd_rs2 always.
- `fu_sel` = stored fu_sel; outputs are passed through, with no arithmetic.
- `load_use_stall` = ex_valid & ex_mem_read & ex_rd_addr≠0 & id_valid & (ex_rd_addr==id_rs1_addr | ex_rd_addr==id_rs2_addr). It compares both source addresses regardless of use_imm. The comparison is conservative and intentional.
- `load_use_stall` is forced 0 while `flush`=1, because the ID instruction is being killed anyway.

## Timing
- Latency: ID values appear on EX outputs one cycle after the capturing edge.
- Forwarding mux and `load_use_stall` are combinational in the same cycle as their inputs.
- Reset (asynchronous assert; release synchronised externally): all stored fields 0.
  - Outputs read `fu_a`=`fu_b`=`ex_store_data`=`ex_pc`=0, `fu_sel`=0, `ex_rd_addr`=0.
  - All 1-bit outputs read 0, including `load_use_stall`.
- Load-use: exactly one bubble, then the dependent instruction enters EX while the load is in WB and forwards from MEM/WB.
- `hold` with `flush`: `hold` wins. Branch logic keeps `flush` asserted until hold drops.
- `hold` with `load_use_stall`: register frozen. The stall output remains asserted, since it is combinational from the frozen state.
- Reset mid-stall or mid-hold: register clears immediately. `load_use_stall` drops in the same cycle.

## Test plan
- Reset → `rst_n`=0 with random inputs → all outputs 0. Release, load ADD x3=x1+x2 (rs1=5, rs2=7, sel=0) → next cycle `fu_a`=5, `fu_b`=7, `ex_valid`=1, `ex_rd_addr`=3.
- Double forward → EX holds rs1=x4. `exm`: x4 ← 0x11. `mwb`: x4 ← 0x22 → `fu_a`=0x11. Drop the exm match → `fu_a`=0x22. Make rs1=x0 with a matching x0 write → `fu_a`=stored 0.
- Load-use → EX holds LW x5; ID `id_rs2_addr`=5 → `load_use_stall`=1. Next edge: `ex_valid`=0. The following edge loads the dependent instruction, and `fu_b` forwards `mwb_result`=0xDEAD.
- Capture bypass → ID reads x6=0 while `mwb` writes x6=0x99 → EX stores 0x99. A later cycle with no forwarding still gives `fu_a`=0x99.
- Flush/hold priority → `flush`=1 with valid ID → bubble (`ex_reg_write`=0). `hold`=1 and `flush`=1 → all outputs unchanged for 3 cycles.
- Immediate/PC select → SLLI with `use_imm`=1, imm=3, sel=4'b1001 → `fu_b`=3, `fu_sel`=9. AUIPC with `use_pc`=1, pc=0x100 → `fu_a`=0x100.
